mips_mem_arbiter: RTL

- Shares one single-ported, variable-latency unified memory between the pipeline's instruction-fetch port (IF stage) and data port (MEM stage).
- Arbitrates between the two ports and runs a req/ack handshake to the memory.
- Returns read data per port and drives per-port stall signals that freeze the pipeline while an access is outstanding.
- Data port normally has priority, because it belongs to the older instruction; a starvation limit guarantees forward progress for fetch.

---
 rtl/mips_mem_arbiter_if.sv | 40 ++++
 rtl/mips_mem_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mips_mem_arbiter_if.sv
// rtl/mips_mem_arbiter_if.sv - fetch/data/memory bus bundle for the unified-memory arbiter
interface mips_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_abort;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ready;
   logic              if_stall;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ready;
   logic              d_stall;

   logic              m_req;
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic [DATA_W-1:0] m_rdata;
   logic              m_ack;
   logic              m_err;

   modport slave (
      input  if_req, if_addr, if_abort, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
      output if_rdata, if_ready, if_stall, d_rdata, d_ready, d_stall,
             m_req, m_we, m_addr, m_wdata, m_err
   );

   modport master (
      output if_req, if_addr, if_abort, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
      input  if_rdata, if_ready, if_stall, d_rdata, d_ready, d_stall,
             m_req, m_we, m_addr, m_wdata, m_err
   );
endinterface

// File: rtl/mips_mem_arbiter.sv
// rtl/mips_mem_arbiter.sv - shares one variable-latency memory between fetch and data ports
module mips_mem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 64
) (
   input logic                clk,
   input logic                reset,
   mips_mem_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY, DONE} state_t;

   state_t            state, state_next;
   logic [3:0]        starve_cnt;
   logic [7:0]        tmo_cnt;
   logic              aborted;
   logic              grant_if, grant_d, busy, acked, expired, fetch_ok;

   logic              m_req_r, m_we_r, m_err_r, if_ready_r, d_ready_r;
   logic [ADDR_W-1:0] m_addr_r;
   logic [DATA_W-1:0] m_wdata_r, if_rdata_r, d_rdata_r;

   assign fetch_ok = bus.if_req & ~bus.if_abort;
   assign busy     = (state == IF_BUSY) || (state == D_BUSY);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      grant_if   = 1'b0;
      grant_d    = 1'b0;
      acked      = 1'b0;
      expired    = 1'b0;
      case (state)
         IDLE: begin
            // Data belongs to the older instruction, so it wins unless fetch has waited too long.
            if (fetch_ok && (!bus.d_req || starve_cnt == 4'(STARVE_LIMIT))) begin
               grant_if   = 1'b1;
               state_next = IF_BUSY;
            end else if (bus.d_req) begin
               grant_d    = 1'b1;
               state_next = D_BUSY;
            end
         end
         IF_BUSY, D_BUSY: begin
            if (bus.m_ack) begin
               acked      = 1'b1;
               state_next = DONE;
            end else if (tmo_cnt == 8'(TIMEOUT - 1)) begin
               expired    = 1'b1;
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt <= '0;
         tmo_cnt    <= '0;
         aborted    <= 1'b0;
         m_req_r    <= 1'b0;
         m_we_r     <= 1'b0;
         m_err_r    <= 1'b0;
         m_addr_r   <= '0;
         m_wdata_r  <= '0;
         if_rdata_r <= '0;
         d_rdata_r  <= '0;
         if_ready_r <= 1'b0;
         d_ready_r  <= 1'b0;
      end else begin
         if_ready_r <= 1'b0;
         d_ready_r  <= 1'b0;
         if (state == IDLE) begin
            if (!bus.if_req || grant_if)
               starve_cnt <= '0;
            else if (grant_d && starve_cnt != 4'(STARVE_LIMIT))
               starve_cnt <= starve_cnt + 4'd1;
         end
         if (grant_if) begin
            m_req_r   <= 1'b1;
            m_we_r    <= 1'b0;
            m_addr_r  <= bus.if_addr;
            m_wdata_r <= '0;
            tmo_cnt   <= '0;
            aborted   <= 1'b0;
         end else if (grant_d) begin
            m_req_r   <= 1'b1;
            m_we_r    <= bus.d_we;
            m_addr_r  <= bus.d_addr;
            m_wdata_r <= bus.d_wdata;
            tmo_cnt   <= '0;
            aborted   <= 1'b0;
         end
         if (busy) begin
            if (state == IF_BUSY && bus.if_abort) aborted <= 1'b1;
            if (acked || expired) begin
               m_req_r <= 1'b0;
               if (expired) m_err_r <= 1'b1;
               if (state == IF_BUSY) begin
                  if_rdata_r <= acked ? bus.m_rdata : '0;
                  // An abort arriving on the completing cycle must still suppress the pulse.
                  if_ready_r <= ~(aborted | bus.if_abort);
               end else begin
                  if (!m_we_r) d_rdata_r <= acked ? bus.m_rdata : '0;
                  d_ready_r <= 1'b1;
               end
            end else begin
               tmo_cnt <= tmo_cnt + 8'd1;
            end
         end
      end
   end

   assign bus.m_req    = m_req_r;
   assign bus.m_we     = m_we_r;
   assign bus.m_addr   = m_addr_r;
   assign bus.m_wdata  = m_wdata_r;
   assign bus.m_err    = m_err_r;
   assign bus.if_rdata = if_rdata_r;
   assign bus.if_ready = if_ready_r;
   assign bus.d_rdata  = d_rdata_r;
   assign bus.d_ready  = d_ready_r;
   assign bus.if_stall = bus.if_req & ~if_ready_r;
   assign bus.d_stall  = bus.d_req & ~d_ready_r;
endmodule
